// File: rtl/calc_rx_pkg.sv
// Shared types and default sizing for the calculator serial-result receive path.
package calc_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } rx_state_t;

    localparam int CALC_FRAME_W  = 32;
    localparam int CALC_RX_DEPTH = 4;

endpackage

// File: rtl/rx_word_fifo.sv
// Synchronous first-word fall-through FIFO; the head word is visible while not empty.
module rx_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign rd_en = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/calc_rx_deframer.sv
// Serial result deframer: edge-detects RxClk, assembles MSB-first frames, buffers words.
// Optional CALC_RX_SYNC_EN adds 2-flop synchronizers on RxData/RxClk/RxValid.
module calc_rx_deframer
    import calc_rx_pkg::*;
#(
    parameter int FRAME_W    = CALC_FRAME_W,
    parameter int FIFO_DEPTH = CALC_RX_DEPTH
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          RxData,
    input  logic                          RxClk,
    input  logic                          RxValid,
    input  logic                          WordReady,
    input  logic                          ClrErr,
    output logic [FRAME_W-1:0]            Word,
    output logic                          WordValid,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          RxBusy,
    output logic                          FrameErr,
    output logic                          Overflow
);

    localparam int CNT_W = $clog2(FRAME_W) + 1;

    logic rx_data_s;
    logic rx_clk_s;
    logic rx_valid_s;

`ifdef CALC_RX_SYNC_EN
    logic [2:0] raw_in;
    logic [2:0] sync_out;

    assign raw_in = {RxValid, RxClk, RxData};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [1:0] stage_reg;
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= {stage_reg[0], raw_in[gi]};
                end
            end
            assign sync_out[gi] = stage_reg[1];
        end
    endgenerate

    assign {rx_valid_s, rx_clk_s, rx_data_s} = sync_out;
`else
    assign rx_data_s  = RxData;
    assign rx_clk_s   = RxClk;
    assign rx_valid_s = RxValid;
`endif

    rx_state_t          state_reg;
    logic [FRAME_W-1:0] sr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               rx_clk_prev_reg;
    logic               busy_reg;
    logic               frame_err_reg;
    logic               overflow_reg;
    logic               sample_evt;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop_hit;

    assign sample_evt = rx_clk_s && !rx_clk_prev_reg && rx_valid_s;
    assign fifo_push  = (state_reg == PUSH);
    assign pop_hit    = !fifo_empty && WordReady;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_clk_prev_reg <= 1'b0;
        end else begin
            rx_clk_prev_reg <= rx_clk_s;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            sr_reg        <= '0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            // Clear first so a same-cycle error below takes precedence.
            if (ClrErr) begin
                frame_err_reg <= 1'b0;
                overflow_reg  <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (sample_evt) begin
                        sr_reg    <= {{(FRAME_W-1){1'b0}}, rx_data_s};
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= SHIFT;
                        busy_reg  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!rx_valid_s) begin
                        frame_err_reg <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                    end else if (sample_evt) begin
                        sr_reg  <= {sr_reg[FRAME_W-2:0], rx_data_s};
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(FRAME_W - 1)) begin
                            state_reg <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    if (fifo_full && !pop_hit) begin
                        overflow_reg <= 1'b1;
                    end
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    rx_word_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Reset),
        .push  (fifo_push),
        .pop   (WordReady),
        .din   (sr_reg),
        .dout  (Word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (Count)
    );

    assign WordValid = !fifo_empty;
    assign RxBusy    = busy_reg;
    assign FrameErr  = frame_err_reg;
    assign Overflow  = overflow_reg;

endmodule

// File: tb/tb_calc_rx_deframer.sv
// Directed bench for calc_rx_deframer with default parameters (32-bit frames, 4-deep FIFO).
module tb_calc_rx_deframer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_data;
    logic        rx_clk;
    logic        rx_valid;
    logic        word_ready;
    logic        clr_err;
    logic [31:0] word;
    logic        word_valid;
    logic [2:0]  count;
    logic        rx_busy;
    logic        frame_err;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    calc_rx_deframer dut (
        .Clk       (clk),
        .Reset     (rst),
        .RxData    (rx_data),
        .RxClk     (rx_clk),
        .RxValid   (rx_valid),
        .WordReady (word_ready),
        .ClrErr    (clr_err),
        .Word      (word),
        .WordValid (word_valid),
        .Count     (count),
        .RxBusy    (rx_busy),
        .FrameErr  (frame_err),
        .Overflow  (overflow)
    );

    // One bit period: RxClk high for 2 Clk cycles, low for 2.
    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        rx_data = b;
        rx_clk  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rx_clk = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_last_bit(input logic b, input bit pop_in_push);
        @(posedge clk); #1;
        rx_data = b;
        rx_clk  = 1'b1;
        @(posedge clk); #1;
        word_ready = pop_in_push;
        @(posedge clk); #1;
        word_ready = 1'b0;
        rx_clk     = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [31:0] w, input bit pop_in_push);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        for (int i = 31; i > 0; i--) send_bit(w[i]);
        send_last_bit(w[0], pop_in_push);
    endtask

    task automatic pop_expect(input logic [31:0] exp, input string tag);
        n_checks++;
        if (word !== exp) begin
            n_fail++;
            $display("FAIL %s: Word=%h expected %h", tag, word, exp);
        end
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_data = 1'b0; rx_clk = 1'b0; rx_valid = 1'b0;
        word_ready = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({word_valid, count, rx_busy, frame_err, overflow} !== 7'b0 || word !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: Word=%h WordValid=%b Count=%0d RxBusy=%b FrameErr=%b Overflow=%b expected all 0",
                     word, word_valid, count, rx_busy, frame_err, overflow);
        end
        rst = 1'b0;
        $display("reset: outputs Word=%h Count=%0d", word, count);
    endtask

    task automatic test_single_frame;
        logic [31:0] w;
        w = 32'hABCD_0123;
        @(posedge clk); #1;
        rx_valid = 1'b1;
        for (int i = 31; i > 0; i--) send_bit(w[i]);
        @(posedge clk); #1;
        rx_data = w[0];
        rx_clk  = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (count !== 3'd0 || rx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_push_cycle: Count=%0d RxBusy=%b expected 0/1", count, rx_busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (word !== w || word_valid !== 1'b1 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_word: Word=%h WordValid=%b Count=%0d expected %h/1/1", word, word_valid, count, w);
        end
        n_checks++;
        if (frame_err !== 1'b0 || rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_flags: FrameErr=%b RxBusy=%b expected 0/0", frame_err, rx_busy);
        end
        rx_clk = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rx_valid   = 1'b0;
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        n_checks++;
        if (word_valid !== 1'b0 || count !== 3'd0 || word !== 32'h0) begin
            n_fail++;
            $display("FAIL single_pop: WordValid=%b Count=%0d Word=%h expected 0/0/0", word_valid, count, word);
        end
        $display("single: received %h", w);
    endtask

    task automatic test_frame_err;
        @(posedge clk); #1;
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        #1 rx_valid = 1'b0;
        n_checks++;
        if (frame_err !== 1'b0 || rx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_before: FrameErr=%b RxBusy=%b expected 0/1", frame_err, rx_busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (frame_err !== 1'b1 || rx_busy !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL ferr_set: FrameErr=%b RxBusy=%b Count=%0d expected 1/0/0", frame_err, rx_busy, count);
        end
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_clear: FrameErr=%b expected 0", frame_err);
        end
        $display("frame_err: short frame after 10 bits flagged and cleared");
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 5; i++) send_frame(32'(i), 1'b0);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b1 || word_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_state: Count=%0d Overflow=%b WordValid=%b expected 4/1/1", count, overflow, word_valid);
        end
        for (int i = 1; i <= 4; i++) pop_expect(32'(i), "ovf_pop");
        n_checks++;
        if (word_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL ovf_drained: WordValid=%b Count=%0d expected 0/0", word_valid, count);
        end
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: Overflow=%b expected 0", overflow);
        end
        $display("overflow: 5 frames into 4-deep FIFO, popped 1..4");
    endtask

    task automatic test_back_to_back_full_pop;
        logic [31:0] exp_q [4];
        exp_q = '{32'h12, 32'h13, 32'h14, 32'h6};
        for (int i = 0; i < 4; i++) send_frame(32'h11 + 32'(i), 1'b0);
        send_frame(32'h6, 1'b1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_state: Count=%0d Overflow=%b expected 4/0", count, overflow);
        end
        for (int i = 0; i < 4; i++) pop_expect(exp_q[i], "fullpop_pop");
        n_checks++;
        if (word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_empty: WordValid=%b expected 0", word_valid);
        end
        $display("back_to_back: push into full FIFO with same-cycle pop accepted");
    endtask

    task automatic test_reset_midframe;
        logic [31:0] w;
        w = 32'hDEAD_BEEF;
        send_frame(32'h55, 1'b0);
        for (int i = 0; i < 16; i++) send_bit(~i[0]);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({word_valid, count, rx_busy, frame_err, overflow} !== 7'b0 || word !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: Word=%h WordValid=%b Count=%0d RxBusy=%b FrameErr=%b Overflow=%b expected all 0",
                     word, word_valid, count, rx_busy, frame_err, overflow);
        end
        rx_valid = 1'b0;
        rx_clk   = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        send_frame(w, 1'b0);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        n_checks++;
        if (word !== w || count !== 3'd1 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_frame: Word=%h Count=%0d FrameErr=%b expected %h/1/0", word, count, frame_err, w);
        end
        pop_expect(w, "midreset_pop");
        $display("reset_midframe: recovered with %h", w);
    endtask

    task automatic test_static_high;
        @(posedge clk); #1;
        rx_clk = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL static_busy: cycle %0d RxBusy=%b expected 0", i, rx_busy);
            end
        end
        n_checks++;
        if (count !== 3'd0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL static_count: Count=%0d FrameErr=%b expected 0/0", count, frame_err);
        end
        rx_valid = 1'b0;
        @(posedge clk); #1;
        rx_clk = 1'b0;
        @(posedge clk);
        $display("static_high: 50 cycles with RxClk high, no sample");
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_frame_err;
        test_overflow;
        test_back_to_back_full_pop;
        test_reset_midframe;
        test_static_high;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_rx_deframer.md
# calc_rx_deframer

Downstream receive stage for the binary calculator's serial result link: samples the serial `DataOut` stream on rising edges of `ClkTx` while `DOutValid` is high, reassembles fixed-width frames, and buffers complete words in a small FIFO. It presents those words to a consumer with a valid/ready handshake. All logic runs in the system `Clk` domain; `ClkTx` is treated as data and edge-detected.

## Interface
- `FRAME_W`, 32, bits per frame, MSB first; legal range 2..64.
- `FIFO_DEPTH`, 4, word-buffer depth; power of two, ≥2.
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `RxData`  in  1  serial bit; connects to upstream `DataOut`.
- `RxClk`  in  1  bit clock; connects to upstream `ClkTx` and is sampled as data.
- `RxValid`  in  1  frame enable; connects to upstream `DOutValid`.
- `WordReady`  in  1  consumer accepts the head word.
- `ClrErr`  in  1  clears the sticky error flags.
- `Word`  out  FRAME_W  FIFO head word; first-word fall-through.
- `WordValid`  out  1  FIFO not empty.
- `Count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `RxBusy`  out  1  high while state is SHIFT or PUSH.
- `FrameErr`  out  1  sticky; a frame ended short.
- `Overflow`  out  1  sticky; a complete word was dropped because the FIFO was full.

## Operation
- Sample event: `RxClk`=1, registered previous `RxClk`=0, and `RxValid`=1. The sample is taken in the same `Clk` cycle as the event.
- Shift register: `sr <= {sr[FRAME_W-2:0], RxData}`. The bit counter `cnt` is `$clog2(FRAME_W)+1` bits wide.
- FSM states and transitions:
  - IDLE → SHIFT on a sample event. Loads the first bit and sets `cnt`=1.
  - SHIFT, on a sample event: shift and increment `cnt`. When `cnt` reaches FRAME_W, go to PUSH.
  - SHIFT with `RxValid`=0 before FRAME_W bits: set `FrameErr`, discard the partial frame, return to IDLE.
  - PUSH lasts one cycle. Write `sr` to the FIFO if space is available, otherwise set `Overflow` and drop the word. Then go to IDLE.
  - A frame that starts while `RxValid` remains high is received normally. Back-to-back frames are supported because PUSH lasts one `Clk` cycle, while bit periods are ≥2 `Clk` cycles.
- FIFO behaviour:
  - Pop occurs when `WordValid` && `WordReady`. A pop when empty is ignored.
  - A push into a full FIFO is accepted if a pop occurs in the same cycle; `Count` is then unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Error flags: `ClrErr` clears both flags. If a new error occurs in the same cycle as `ClrErr`, the error wins and the flag stays set.
- Reset values: all outputs are 0, `Word`=0, FSM=IDLE, `cnt`=0, and the FIFO is empty.
- Reset mid-frame drops the partial frame and all buffered words. The first sample event after reset is treated as bit 0 of a new frame.

## Timing
- Let E be the `Clk` cycle in which the last bit's sample event is detected.
  - The FSM is in PUSH in cycle E+1.
  - `WordValid`/`Word`/`Count` update at the E+2 edge, giving 2-cycle latency from the last bit.
- `FrameErr` asserts on the `Clk` edge after `RxValid` is seen low in SHIFT.
- `RxBusy` rises on the edge after the first sample event and falls on the edge after PUSH.
- A pop updates `Word`/`Count` on the next edge. There is no combinational path from `WordReady` to `Word`.
- `RxClk` must be high for ≥1 `Clk` cycle and low for ≥1 `Clk` cycle; a sample event fires only once per high phase.

## Configuration
- `CALC_RX_SYNC_EN`
  - Defined: `RxData`, `RxClk` and `RxValid` each pass through a 2-flop synchronizer before edge detection. All latencies above increase by 2 `Clk` cycles.
  - Undefined: the inputs are used directly because upstream signals are `Clk`-synchronous. Timing is exactly as stated above.

## Structure
- Package `calc_rx_pkg` holds:
  - the state enum `rx_state_t` (IDLE, SHIFT, PUSH);
  - the default constants `CALC_FRAME_W`=32 and `CALC_RX_DEPTH`=4.
- Sub-module `rx_word_fifo` is a synchronous FWFT FIFO with parameters (WIDTH, DEPTH) and ports push/pop/full/empty/count. The deframer FSM is in the top module.

## Test plan
- Send 32'hABCD_0123 MSB first with a 4-`Clk` bit period and `WordReady`=0 → `Word`=32'hABCD_0123, `WordValid`=1, `Count`=1 at E+2, `FrameErr`=0.
- Drop `RxValid` after 10 bits → `FrameErr`=1, `Count`=0, FSM returns to IDLE. Then pulse `ClrErr` → `FrameErr`=0.
- Send 5 frames 32'h1..32'h5 with `WordReady`=0 → `Count`=4, `Overflow`=1. Popping then yields 1, 2, 3, 4, then `WordValid`=0.
- With the FIFO full, hold `WordReady`=1 during PUSH of 32'h6 → `Count` stays 4, `Overflow` stays 0, and 32'h6 is the last word popped.
- Assert `Reset` after 16 bits of a frame → all outputs 0. A following full frame 32'hDEAD_BEEF is received correctly.
- Hold `RxValid`=1 with `RxClk` static high for 50 cycles → no shift, `RxBusy`=0, `Count` unchanged.
